md_hilo_unit: RTL and testbench

//  Execute-stage multiply/divide unit and HI/LO register pair. Receives the MD control bundle

---
 rtl/md_hilo_unit.sv | 153 +++++++++++++++
 tb/tb_md_hilo_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_unit.sv
// Multi-cycle multiply/divide unit with its HI/LO register pair for the execute stage.
// Optional MD_DIV0_FLAG_EN adds a DivByZero pulse and leaves HI/LO intact on a zero divisor.
module md_hilo_unit #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MdStartE,
  input  logic [1:0]  MdOpE,
  input  logic        HiLoWriteE,
  input  logic        HiLoE,
  input  logic        FlushE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] HiOut,
`ifdef MD_DIV0_FLAG_EN
  output logic [31:0] LoOut,
  output logic        DivByZero
`else
  output logic [31:0] LoOut
`endif
);

  localparam int DIV_CYCLES = 33;
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES);

  typedef enum logic [1:0] {IDLE, MUL, DIV} MdState;

  MdState             state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   countNext;
  logic [CNT_W-1:0]   lastCount;
  logic               opSigned;
  logic [31:0]        aReg;
  logic [31:0]        bReg;
  logic [31:0]        quot;
  logic [31:0]        rem;
  logic [31:0]        divisor;

  logic [31:0]        absA;
  logic [31:0]        absB;
  logic [63:0]        aWide;
  logic [63:0]        bWide;
  logic [63:0]        prod;
  logic [32:0]        shifted;
  logic               trialOk;
  logic [31:0]        remNext;
  logic [31:0]        quotNext;
  logic               quotNeg;
  logic               remNeg;
  logic [31:0]        quotFix;
  logic [31:0]        remFix;
  logic               divZero;

  assign countNext = count + CNT_W'(1);
  assign lastCount = (state == DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  assign absA = (MdOpE[0] & SrcAE[31]) ? (32'd0 - SrcAE) : SrcAE;
  assign absB = (MdOpE[0] & SrcBE[31]) ? (32'd0 - SrcBE) : SrcBE;

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign aWide = {{32{opSigned & aReg[31]}}, aReg};
  assign bWide = {{32{opSigned & bReg[31]}}, bReg};
  assign prod  = aWide * bWide;

  assign shifted  = {rem, quot[31]};
  assign trialOk  = (shifted >= {1'b0, divisor});
  assign remNext  = trialOk ? 32'(shifted - {1'b0, divisor}) : shifted[31:0];
  assign quotNext = {quot[30:0], trialOk};

  assign quotNeg = opSigned & (aReg[31] ^ bReg[31]);
  assign remNeg  = opSigned & aReg[31];
  assign quotFix = quotNeg ? (32'd0 - quot) : quot;
  assign remFix  = remNeg ? (32'd0 - rem) : rem;
  assign divZero = (bReg == 32'd0);

  // DoneE/DivByZero are registered one edge ahead so they line up with the final busy cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      count    <= '0;
      BusyE    <= 1'b0;
      DoneE    <= 1'b0;
      HiOut    <= 32'd0;
      LoOut    <= 32'd0;
      opSigned <= 1'b0;
      aReg     <= 32'd0;
      bReg     <= 32'd0;
      quot     <= 32'd0;
      rem      <= 32'd0;
      divisor  <= 32'd0;
`ifdef MD_DIV0_FLAG_EN
      DivByZero <= 1'b0;
`endif
    end else begin
      DoneE <= 1'b0;
`ifdef MD_DIV0_FLAG_EN
      DivByZero <= 1'b0;
`endif
      if (state == IDLE) begin
        if (HiLoWriteE) begin
          if (HiLoE) HiOut <= SrcAE;
          else       LoOut <= SrcAE;
        end
        if (MdStartE && !FlushE) begin
          state    <= MdOpE[1] ? DIV : MUL;
          count    <= '0;
          BusyE    <= 1'b1;
          DoneE    <= !MdOpE[1] && (MUL_CYCLES == 1);
          opSigned <= MdOpE[0];
          aReg     <= SrcAE;
          bReg     <= SrcBE;
          quot     <= absA;
          rem      <= 32'd0;
          divisor  <= absB;
        end
      end else if (count == lastCount) begin
        // Completion takes priority over a coincident flush.
        state <= IDLE;
        BusyE <= 1'b0;
        if (state == MUL) begin
          HiOut <= prod[63:32];
          LoOut <= prod[31:0];
        end else if (divZero) begin
`ifndef MD_DIV0_FLAG_EN
          HiOut <= aReg;
          LoOut <= 32'hFFFF_FFFF;
`endif
        end else begin
          HiOut <= remFix;
          LoOut <= quotFix;
        end
      end else if (FlushE) begin
        state <= IDLE;
        BusyE <= 1'b0;
      end else begin
        count <= countNext;
        DoneE <= (countNext == lastCount);
`ifdef MD_DIV0_FLAG_EN
        DivByZero <= (countNext == lastCount) && (state == DIV) && divZero;
`endif
        if (state == DIV) begin
          quot <= quotNext;
          rem  <= remNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed self-checking bench for md_hilo_unit: multiply, divide, MT writes, flush and reset.
// Define MD_DIV0_FLAG_EN to check the divide-by-zero flag build.
module tb_md_hilo_unit;

  logic        Clk;
  logic        Rst_n;
  logic        MdStartE;
  logic [1:0]  MdOpE;
  logic        HiLoWriteE;
  logic        HiLoE;
  logic        FlushE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
`ifdef MD_DIV0_FLAG_EN
  logic        DivByZero;
`endif

  int          checks;
  int          failures;
  logic [31:0] curHi;
  logic [31:0] curLo;

  md_hilo_unit #(.MUL_CYCLES(4)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .MdStartE(MdStartE),
    .MdOpE(MdOpE),
    .HiLoWriteE(HiLoWriteE),
    .HiLoE(HiLoE),
    .FlushE(FlushE),
    .SrcAE(SrcAE),
    .SrcBE(SrcBE),
    .BusyE(BusyE),
    .DoneE(DoneE),
    .HiOut(HiOut),
`ifdef MD_DIV0_FLAG_EN
    .LoOut(LoOut),
    .DivByZero(DivByZero)
`else
    .LoOut(LoOut)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // inject: 0 none, 1 restart in cycle 2, 2 MTLO in cycle 2, 3 MTLO alongside the start.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int n, input logic [31:0] eHi, input logic [31:0] eLo,
                               input logic eDz, input int inject, input int flushAt);
    MdStartE = 1'b1;
    MdOpE    = op;
    SrcAE    = a;
    SrcBE    = b;
    if (inject == 3) begin
      HiLoWriteE = 1'b1;
      HiLoE      = 1'b0;
    end
    @(posedge Clk); #1;
    if (inject == 3) curLo = a;
    MdStartE   = 1'b0;
    HiLoWriteE = 1'b0;
    SrcAE      = ~a;
    SrcBE      = b + 32'd7;
    for (int k = 1; k <= n; k++) begin
      checkOutput("busy", {31'd0, BusyE}, 32'd1);
      checkOutput("done", {31'd0, DoneE}, {31'd0, (k == n)});
      checkOutput("hiHold", HiOut, curHi);
      checkOutput("loHold", LoOut, curLo);
`ifdef MD_DIV0_FLAG_EN
      checkOutput("divByZero", {31'd0, DivByZero}, {31'd0, (k == n) & eDz});
`endif
      if (inject == 1 && k == 2) begin
        MdStartE = 1'b1;
        MdOpE    = 2'b10;
        SrcAE    = 32'd100;
        SrcBE    = 32'd3;
      end
      if (inject == 2 && k == 2) begin
        HiLoWriteE = 1'b1;
        HiLoE      = 1'b0;
        SrcAE      = 32'hDEAD;
      end
      if (k == flushAt) FlushE = 1'b1;
      @(posedge Clk); #1;
      MdStartE   = 1'b0;
      HiLoWriteE = 1'b0;
      FlushE     = 1'b0;
      if (k == flushAt && k < n) begin
        checkOutput("flushBusy", {31'd0, BusyE}, 32'd0);
        checkOutput("flushDone", {31'd0, DoneE}, 32'd0);
        checkOutput("flushHi", HiOut, curHi);
        checkOutput("flushLo", LoOut, curLo);
        return;
      end
    end
    curHi = eHi;
    curLo = eLo;
    checkOutput("endBusy", {31'd0, BusyE}, 32'd0);
    checkOutput("endDone", {31'd0, DoneE}, 32'd0);
    checkOutput("resultHi", HiOut, curHi);
    checkOutput("resultLo", LoOut, curLo);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    curHi      = 32'd0;
    curLo      = 32'd0;
    Rst_n      = 1'b0;
    MdStartE   = 1'b0;
    MdOpE      = 2'b00;
    HiLoWriteE = 1'b0;
    HiLoE      = 1'b0;
    FlushE     = 1'b0;
    SrcAE      = 32'd0;
    SrcBE      = 32'd0;
    #2;
    checkOutput("rstBusy", {31'd0, BusyE}, 32'd0);
    checkOutput("rstDone", {31'd0, DoneE}, 32'd0);
    checkOutput("rstHi", HiOut, 32'd0);
    checkOutput("rstLo", LoOut, 32'd0);
    #10;
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd2, 4, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0, 0);
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd5, 4, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1, 0);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
    applyStimulus(2'b10, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 0, 0);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, 0, 0);
    applyStimulus(2'b11, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0, 0, 0);
`ifdef MD_DIV0_FLAG_EN
    applyStimulus(2'b10, 32'd5, 32'd0, 33, curHi, curLo, 1'b1, 0, 0);
`else
    applyStimulus(2'b10, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, 1'b0, 0, 0);
`endif

    HiLoWriteE = 1'b1;
    HiLoE      = 1'b1;
    SrcAE      = 32'h1234;
    @(posedge Clk); #1;
    HiLoWriteE = 1'b0;
    curHi      = 32'h1234;
    checkOutput("mthiHi", HiOut, curHi);
    checkOutput("mthiLo", LoOut, curLo);

    applyStimulus(2'b00, 32'd3, 32'd4, 4, 32'd0, 32'd12, 1'b0, 2, 0);
    applyStimulus(2'b10, 32'd100, 32'd7, 33, curHi, curLo, 1'b0, 0, 10);

    MdStartE = 1'b1;
    FlushE   = 1'b1;
    MdOpE    = 2'b00;
    SrcAE    = 32'd9;
    SrcBE    = 32'd9;
    @(posedge Clk); #1;
    MdStartE = 1'b0;
    FlushE   = 1'b0;
    checkOutput("idleFlushBusy", {31'd0, BusyE}, 32'd0);
    checkOutput("idleFlushLo", LoOut, curLo);

    applyStimulus(2'b00, 32'd6, 32'd7, 4, 32'd0, 32'd42, 1'b0, 3, 0);
    applyStimulus(2'b00, 32'd3, 32'd3, 4, 32'd0, 32'd9, 1'b0, 0, 4);

    MdStartE = 1'b1;
    MdOpE    = 2'b01;
    SrcAE    = 32'd3;
    SrcBE    = 32'd3;
    @(posedge Clk); #1;
    MdStartE = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", {31'd0, BusyE}, 32'd0);
    checkOutput("midRstDone", {31'd0, DoneE}, 32'd0);
    checkOutput("midRstHi", HiOut, 32'd0);
    checkOutput("midRstLo", LoOut, 32'd0);
    Rst_n = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    checkOutput("postRstBusy", {31'd0, BusyE}, 32'd0);
    checkOutput("postRstLo", LoOut, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
